// File: rtl/doa_pkg.sv
// Shared DOA types and widths used by peak_bin_detector and weightblock.
package doa_pkg;

  localparam int ADDR_W = 10;
  localparam int DW     = 14;
  localparam int MAG_W  = 2*DW + 1;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

endpackage

// File: rtl/mag_sq.sv
// Two-stage pipelined |x|^2: squares registered, then their sum registered.
// A valid bit and a tag ride alongside the data.
module mag_sq
  import doa_pkg::*;
#(
  parameter int TAG_W = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  input  cplx_t            in_data,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag,
  output mag_t             out_mag
);

  logic signed [2*DW-1:0] re_p, im_p;
  logic [2*DW-1:0]        re_sq_d, re_sq_q, im_sq_d, im_sq_q;
  logic                   vld1_d, vld1_q, vld2_d, vld2_q;
  logic [TAG_W-1:0]       tag1_d, tag1_q, tag2_d, tag2_q;
  mag_t                   sum_d, sum_q;

  always_comb begin
    re_p    = in_data.re * in_data.re;
    im_p    = in_data.im * in_data.im;
    re_sq_d = re_p;
    im_sq_d = im_p;
    vld1_d  = in_vld;
    tag1_d  = in_tag;
    // both squares are non-negative, so widening by one bit cannot overflow
    sum_d   = MAG_W'(re_sq_q) + MAG_W'(im_sq_q);
    vld2_d  = vld1_q;
    tag2_d  = tag1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_sq_q <= '0;
      im_sq_q <= '0;
      vld1_q  <= 1'b0;
      tag1_q  <= '0;
      sum_q   <= '0;
      vld2_q  <= 1'b0;
      tag2_q  <= '0;
    end else begin
      re_sq_q <= re_sq_d;
      im_sq_q <= im_sq_d;
      vld1_q  <= vld1_d;
      tag1_q  <= tag1_d;
      sum_q   <= sum_d;
      vld2_q  <= vld2_d;
      tag2_q  <= tag2_d;
    end
  end

  assign out_vld = vld2_q;
  assign out_tag = tag2_q;
  assign out_mag = sum_q;

endmodule

// File: rtl/peak_bin_detector.sv
// Scans mic-1 FFT_RAM over bins BIN_LO..BIN_HI and reports the bin with the largest |X|^2.
// Optional PEAK_THRESH_EN adds thresh/peakvalid and suppresses detectdone below threshold.
module peak_bin_detector
  import doa_pkg::*;
#(
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fftdone,
  input  logic [2*DW-1:0]   ramq1,
`ifdef PEAK_THRESH_EN
  input  logic [MAG_W-1:0]  thresh,
  output logic              peakvalid,
`endif
  output logic [ADDR_W-1:0] rdaddr1,
  output logic              busy,
  output logic              detectdone,
  output logic [ADDR_W-1:0] maxbin,
  output logic [MAG_W-1:0]  maxmag
);

  localparam logic [ADDR_W-1:0] BIN_LO_A = ADDR_W'(BIN_LO);
  localparam logic [ADDR_W-1:0] BIN_HI_A = ADDR_W'(BIN_HI);

  state_t            state_d, state_q;
  logic [ADDR_W-1:0] rdaddr_d, rdaddr_q;
  logic [1:0]        drain_d, drain_q;
  logic              rd_vld_d, rd_vld_q;
  logic [ADDR_W-1:0] rd_bin_d, rd_bin_q;
  mag_t              best_mag_d, best_mag_q;
  logic [ADDR_W-1:0] best_bin_d, best_bin_q;
  logic [ADDR_W-1:0] maxbin_d, maxbin_q;
  mag_t              maxmag_d, maxmag_q;
  logic              done_d, done_q;
  logic              pv_d, pv_q;

  cplx_t             ram_c;
  logic              m_vld;
  logic [ADDR_W-1:0] m_bin;
  mag_t              m_mag;

  assign ram_c = ramq1;

  mag_sq #(.TAG_W(ADDR_W)) u_mag_sq (
    .clk     (clk),
    .rst     (reset),
    .in_vld  (rd_vld_q),
    .in_tag  (rd_bin_q),
    .in_data (ram_c),
    .out_vld (m_vld),
    .out_tag (m_bin),
    .out_mag (m_mag)
  );

  always_comb begin
    state_d    = state_q;
    rdaddr_d   = rdaddr_q;
    drain_d    = drain_q;
    best_mag_d = best_mag_q;
    best_bin_d = best_bin_q;
    maxbin_d   = maxbin_q;
    maxmag_d   = maxmag_q;
    done_d     = 1'b0;
    pv_d       = pv_q;
    // tag registered alongside the 1-cycle RAM read so it lines up with ramq1
    rd_vld_d   = (state_q == SCAN);
    rd_bin_d   = rdaddr_q;

    // strict compare keeps the lowest bin on ties
    if (m_vld && (m_mag > best_mag_q)) begin
      best_mag_d = m_mag;
      best_bin_d = m_bin;
    end

    unique case (state_q)
      IDLE: begin
        if (fftdone) begin
          state_d    = SCAN;
          rdaddr_d   = BIN_LO_A;
          drain_d    = '0;
          best_mag_d = '0;
          best_bin_d = BIN_LO_A;
        end
      end
      SCAN: begin
        if (rdaddr_q == BIN_HI_A) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          rdaddr_d = rdaddr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd2) state_d = DONE;
        else                 drain_d = drain_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
`ifdef PEAK_THRESH_EN
        if (best_mag_q >= thresh) begin
          done_d   = 1'b1;
          maxbin_d = best_bin_q;
          maxmag_d = best_mag_q;
          pv_d     = 1'b1;
        end else begin
          pv_d     = 1'b0;
        end
`else
        done_d   = 1'b1;
        maxbin_d = best_bin_q;
        maxmag_d = best_mag_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rdaddr_q   <= '0;
      drain_q    <= '0;
      rd_vld_q   <= 1'b0;
      rd_bin_q   <= '0;
      best_mag_q <= '0;
      best_bin_q <= '0;
      maxbin_q   <= '0;
      maxmag_q   <= '0;
      done_q     <= 1'b0;
      pv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdaddr_q   <= rdaddr_d;
      drain_q    <= drain_d;
      rd_vld_q   <= rd_vld_d;
      rd_bin_q   <= rd_bin_d;
      best_mag_q <= best_mag_d;
      best_bin_q <= best_bin_d;
      maxbin_q   <= maxbin_d;
      maxmag_q   <= maxmag_d;
      done_q     <= done_d;
      pv_q       <= pv_d;
    end
  end

  assign rdaddr1    = rdaddr_q;
  assign busy       = (state_q != IDLE);
  assign detectdone = done_q;
  assign maxbin     = maxbin_q;
  assign maxmag     = maxmag_q;
`ifdef PEAK_THRESH_EN
  assign peakvalid  = pv_q;
`else
  logic unused_pv;
  assign unused_pv = pv_q;
`endif

endmodule

// File: tb/tb_peak_bin_detector.sv
// Directed self-checking bench for peak_bin_detector with a 1-cycle-latency FFT_RAM model.
module tb_peak_bin_detector;
  import doa_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              fftdone;
  logic [2*DW-1:0]   ramq1 = '0;
  logic [ADDR_W-1:0] rdaddr1;
  logic              busy;
  logic              detectdone;
  logic [ADDR_W-1:0] maxbin;
  logic [MAG_W-1:0]  maxmag;
`ifdef PEAK_THRESH_EN
  logic [MAG_W-1:0]  thresh;
  logic              peakvalid;
`endif

  logic [2*DW-1:0] mem [0:(1<<ADDR_W)-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ramq1 <= mem[rdaddr1];

  peak_bin_detector dut (
    .clk        (clk),
    .reset      (reset),
    .fftdone    (fftdone),
    .ramq1      (ramq1),
`ifdef PEAK_THRESH_EN
    .thresh     (thresh),
    .peakvalid  (peakvalid),
`endif
    .rdaddr1    (rdaddr1),
    .busy       (busy),
    .detectdone (detectdone),
    .maxbin     (maxbin),
    .maxmag     (maxmag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
  endtask

  task automatic set_bin(input int idx, input int re, input int im);
    logic [DW-1:0] r, m;
    r = DW'(re);
    m = DW'(im);
    mem[idx] = {r, m};
  endtask

  // Pulses fftdone, then watches cycles 1..len counted from the fftdone sample edge.
  task automatic run_scan(input int len, input int restart_at,
                          output int first, output int cnt, output logic busy1);
    first = -1;
    cnt   = 0;
    busy1 = 1'b0;
    @(posedge clk); #1 fftdone = 1'b1;
    @(posedge clk); #1 fftdone = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (c == 1) busy1 = busy;
      if (detectdone) begin
        cnt++;
        if (first < 0) first = c;
      end
      fftdone = (c == restart_at);
      @(posedge clk); #1;
    end
    fftdone = 1'b0;
  endtask

  int   first, cnt;
  logic busy1;

  initial begin
    reset   = 1'b1;
    fftdone = 1'b0;
`ifdef PEAK_THRESH_EN
    thresh  = '0;
`endif
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdaddr1", 64'(rdaddr1), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_detectdone", 64'(detectdone), 64'd0);
    chk("reset_maxbin", 64'(maxbin), 64'd0);
    chk("reset_maxmag", 64'(maxmag), 64'd0);
`ifdef PEAK_THRESH_EN
    chk("reset_peakvalid", 64'(peakvalid), 64'd0);
`endif
    reset = 1'b0;

    // tone: 226^2 + 310^2 = 51076 + 96100 = 147176
    for (int i = 0; i < (1<<ADDR_W); i++) set_bin(i, 3, -2);
    set_bin(44, -226, -310);
    run_scan(560, 0, first, cnt, busy1);
    chk("tone_done_cycle", 64'(first), 64'd516);
    chk("tone_done_count", 64'(cnt), 64'd1);
    chk("tone_busy_start", 64'(busy1), 64'd1);
    chk("tone_busy_end", 64'(busy), 64'd0);
    chk("tone_rdaddr_hold", 64'(rdaddr1), 64'd511);
    chk("tone_maxbin", 64'(maxbin), 64'd44);
    chk("tone_maxmag", 64'(maxmag), 64'd147176);
`ifdef PEAK_THRESH_EN
    chk("tone_peakvalid", 64'(peakvalid), 64'd1);
`endif

    // tie: lowest bin wins
    clear_mem();
    set_bin(44, 400, 0);
    set_bin(100, 400, 0);
    run_scan(560, 0, first, cnt, busy1);
    chk("tie_done_count", 64'(cnt), 64'd1);
    chk("tie_maxbin", 64'(maxbin), 64'd44);
    chk("tie_maxmag", 64'(maxmag), 64'd160000);

    // range: extremes at the top bin, large values outside the range ignored
    clear_mem();
    set_bin(511, -8192, -8192);
    set_bin(0, 8191, 8191);
    set_bin(600, 8191, 8191);
    run_scan(560, 0, first, cnt, busy1);
    chk("range_maxbin", 64'(maxbin), 64'd511);
    chk("range_maxmag", 64'(maxmag), 64'd134217728);

    // all in-range bins zero, only DC populated
    clear_mem();
    set_bin(0, 8191, 8191);
    set_bin(512, 100, 100);
    run_scan(560, 0, first, cnt, busy1);
    chk("zero_done_count", 64'(cnt), 64'd1);
    chk("zero_maxbin", 64'(maxbin), 64'd1);
    chk("zero_maxmag", 64'(maxmag), 64'd0);

    // reset mid-scan
    for (int i = 0; i < (1<<ADDR_W); i++) set_bin(i, 3, -2);
    set_bin(44, -226, -310);
    run_scan(100, 0, first, cnt, busy1);
    reset = 1'b1;
    #1;
    chk("rst_mid_rdaddr1", 64'(rdaddr1), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_detectdone", 64'(detectdone), 64'd0);
    chk("rst_mid_maxbin", 64'(maxbin), 64'd0);
    chk("rst_mid_maxmag", 64'(maxmag), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 600; c++) begin
      if (detectdone) cnt++;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_done", 64'(cnt), 64'd0);
    run_scan(560, 0, first, cnt, busy1);
    chk("rst_rescan_cycle", 64'(first), 64'd516);
    chk("rst_rescan_maxbin", 64'(maxbin), 64'd44);

    // fftdone while busy is ignored
    run_scan(1100, 50, first, cnt, busy1);
    chk("busy_done_count", 64'(cnt), 64'd1);
    chk("busy_done_cycle", 64'(first), 64'd516);
    chk("busy_maxbin", 64'(maxbin), 64'd44);

`ifdef PEAK_THRESH_EN
    // below threshold: no pulse, previous result retained
    clear_mem();
    set_bin(7, 400, 0);
    run_scan(560, 0, first, cnt, busy1);
    chk("th_prep_maxbin", 64'(maxbin), 64'd7);
    for (int i = 0; i < (1<<ADDR_W); i++) set_bin(i, 3, -2);
    set_bin(44, -226, -310);
    thresh = MAG_W'(200000);
    run_scan(560, 0, first, cnt, busy1);
    chk("th_high_no_done", 64'(cnt), 64'd0);
    chk("th_high_peakvalid", 64'(peakvalid), 64'd0);
    chk("th_high_maxbin_kept", 64'(maxbin), 64'd7);
    chk("th_high_maxmag_kept", 64'(maxmag), 64'd160000);
    chk("th_high_busy_end", 64'(busy), 64'd0);
    thresh = MAG_W'(100000);
    run_scan(560, 0, first, cnt, busy1);
    chk("th_low_done_count", 64'(cnt), 64'd1);
    chk("th_low_peakvalid", 64'(peakvalid), 64'd1);
    chk("th_low_maxbin", 64'(maxbin), 64'd44);
    chk("th_low_maxmag", 64'(maxmag), 64'd147176);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
